// File: rtl/i2s_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2s_rx_pkg                                                      |
// | Purpose  : Shared types and default sizes for the I2S receive front-end.   |
// |            Contains the receiver state encoding and the default values    |
// |            for the captured word width, the slot-loss threshold and the   |
// |            synchronizer depth.                                            |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package i2s_rx_pkg;

  // Receiver alignment state
  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } rx_state_e;

  localparam int DATA_W_DEFAULT      = 24;
  localparam int SLOT_MAX_DEFAULT    = 64;
  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage : i2s_rx_pkg
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_edge                                                       |
// | Purpose  : STAGES-deep synchronizer for one asynchronous input, followed  |
// |            by a registered rising-edge detector on the synchronized value.|
// | Ports    : clk    in  1  sampling clock                                   |
// |            rst_n  in  1  asynchronous reset, active-low                   |
// |            d      in  1  asynchronous input                               |
// |            rise   out 1  high for one clk when synchronized d goes 0->1   |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  // Shift form works for any depth, including a single stage.
  always_comb begin
    sync_d = (sync_q << 1) | STAGES'(d);
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Rise is combinational from the last sync stage, so it is aligned with
  // other signals passed through the same number of stages.
  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule : sync_edge
`default_nettype wire

// File: rtl/i2s_rx_deser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2s_rx_deser                                                    |
// | Purpose  : Oversampling Philips-I2S receiver. Synchronizes bclk/ws/sdata  |
// |            into sys_clk, aligns on the ws 1->0 edge, deserializes MSB-    |
// |            first left/right words and presents them as a pair with a      |
// |            one-cycle strobe. Short slots and lost sync pulse frame_err.   |
// | Ports    : sys_clk     in  1       system clock                           |
// |            sys_rst     in  1       asynchronous reset, active-low         |
// |            bclk        in  1       I2S bit clock (asynchronous)           |
// |            ws          in  1       word select, 0 = left, 1 = right       |
// |            sdata       in  1       serial data                            |
// |            left_data   out DATA_W  last complete left word                |
// |            right_data  out DATA_W  last complete right word               |
// |            sample_vld  out 1       pulse: left/right_data updated         |
// |            frame_err   out 1       pulse: short slot or lost sync         |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module i2s_rx_deser
  import i2s_rx_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int SLOT_MAX    = SLOT_MAX_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              bclk,
  input  logic              ws,
  input  logic              sdata,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_vld,
  output logic              frame_err
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int SLOT_W = $clog2(SLOT_MAX + 1);

  // ---------------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------------
  logic bclk_rise;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_bclk_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst),
    .d     (bclk),
    .rise  (bclk_rise)
  );

  // ws and sdata use the same depth, so their last stage lines up with the
  // cycle in which bclk_rise is reported.
  logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic                   ws_s;
  logic                   sd_s;

  always_comb begin
    ws_sync_d = (ws_sync_q << 1) | SYNC_STAGES'(ws);
    sd_sync_d = (sd_sync_q << 1) | SYNC_STAGES'(sdata);
  end

  assign ws_s = ws_sync_q[SYNC_STAGES-1];
  assign sd_s = sd_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  rx_state_e          state_q, state_d;
  logic               ws_prev_q, ws_prev_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic [DATA_W-1:0]  left_hold_q, left_hold_d;
  logic [DATA_W-1:0]  left_data_q, left_data_d;
  logic [DATA_W-1:0]  right_data_q, right_data_d;
  logic               sample_vld_q, sample_vld_d;
  logic               frame_err_q, frame_err_d;

  // Bit captured on the current rise, applied before any slot finalization:
  // the bit on which ws is seen changing is the LSB of the slot just ending.
  logic [DATA_W-1:0]  cap_shreg;
  logic [CNT_W-1:0]   cap_cnt;
  logic [DATA_W-1:0]  cap_word;
  logic               cap_short;
  logic               ws_change;
  logic               slot_lost;

  always_comb begin
    cap_shreg = shreg_q;
    cap_cnt   = bit_cnt_q;
    if (bit_cnt_q < CNT_W'(DATA_W)) begin
      cap_shreg = (shreg_q << 1) | DATA_W'(sd_s);
      cap_cnt   = bit_cnt_q + CNT_W'(1);
    end
    // Left-justify a short word; unfilled LSBs come in as zero.
    cap_word  = cap_shreg << (CNT_W'(DATA_W) - cap_cnt);
    cap_short = (cap_cnt < CNT_W'(DATA_W));
    ws_change = (ws_s != ws_prev_q);
    slot_lost = ((slot_cnt_q + SLOT_W'(1)) == SLOT_W'(SLOT_MAX));
  end

  always_comb begin
    state_d      = state_q;
    ws_prev_d    = ws_prev_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    slot_cnt_d   = slot_cnt_q;
    left_hold_d  = left_hold_q;
    left_data_d  = left_data_q;
    right_data_d = right_data_q;
    sample_vld_d = 1'b0;
    frame_err_d  = 1'b0;

    if (bclk_rise) begin
      ws_prev_d = ws_s;
      case (state_q)
        WAIT_SYNC: begin
          if (ws_prev_q && !ws_s) begin
            state_d    = LEFT;
            shreg_d    = '0;
            bit_cnt_d  = '0;
            slot_cnt_d = '0;
          end
        end

        LEFT, RIGHT: begin
          if (ws_change) begin
            // In LEFT ws can only change 0->1, in RIGHT only 1->0.
            if (state_q == LEFT) begin
              left_hold_d = cap_word;
              state_d     = RIGHT;
            end else begin
              left_data_d  = left_hold_q;
              right_data_d = cap_word;
              sample_vld_d = 1'b1;
              state_d      = LEFT;
            end
            frame_err_d = cap_short;
            shreg_d     = '0;
            bit_cnt_d   = '0;
            slot_cnt_d  = '0;
          end else if (slot_lost) begin
            frame_err_d = 1'b1;
            state_d     = WAIT_SYNC;
            shreg_d     = '0;
            bit_cnt_d   = '0;
            slot_cnt_d  = '0;
          end else begin
            shreg_d    = cap_shreg;
            bit_cnt_d  = cap_cnt;
            slot_cnt_d = slot_cnt_q + SLOT_W'(1);
          end
        end

        default: begin
          state_d = WAIT_SYNC;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      ws_sync_q    <= '0;
      sd_sync_q    <= '0;
      state_q      <= WAIT_SYNC;
      ws_prev_q    <= 1'b0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      slot_cnt_q   <= '0;
      left_hold_q  <= '0;
      left_data_q  <= '0;
      right_data_q <= '0;
      sample_vld_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      ws_sync_q    <= ws_sync_d;
      sd_sync_q    <= sd_sync_d;
      state_q      <= state_d;
      ws_prev_q    <= ws_prev_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      slot_cnt_q   <= slot_cnt_d;
      left_hold_q  <= left_hold_d;
      left_data_q  <= left_data_d;
      right_data_q <= right_data_d;
      sample_vld_q <= sample_vld_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign left_data  = left_data_q;
  assign right_data = right_data_q;
  assign sample_vld = sample_vld_q;
  assign frame_err  = frame_err_q;

endmodule : i2s_rx_deser
`default_nettype wire

// File: tb/tb_i2s_rx_deser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_i2s_rx_deser                                                 |
// | Purpose  : Scoreboard bench for i2s_rx_deser. Stimulus pushes expected    |
// |            left/right pairs; a monitor pops and compares on sample_vld.   |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_i2s_rx_deser;

  localparam int DW        = 24;
  localparam int HALF_SYS  = 10;   // 50 MHz
  localparam int HALF_BCLK = 195;  // ~2.56 MHz

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          bclk    = 1'b0;
  logic          ws      = 1'b0;
  logic          sdata   = 1'b0;
  logic [DW-1:0] left_data;
  logic [DW-1:0] right_data;
  logic          sample_vld;
  logic          frame_err;

  i2s_rx_deser #(
    .DATA_W      (DW),
    .SYNC_STAGES (2),
    .SLOT_MAX    (64)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .bclk       (bclk),
    .ws         (ws),
    .sdata      (sdata),
    .left_data  (left_data),
    .right_data (right_data),
    .sample_vld (sample_vld),
    .frame_err  (frame_err)
  );

  always #(HALF_SYS) sys_clk = ~sys_clk;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  pair_t exp_q[$];
  pair_t mon_e;
  int    n_cmp    = 0;
  int    n_bad    = 0;
  int    err_seen = 0;
  int    err_base = 0;

  // ---------------------------------------------------------------------------
  // Monitor: pops one expected pair per sample_vld, counts frame_err pulses.
  // ---------------------------------------------------------------------------
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      if (frame_err) err_seen = err_seen + 1;
      if (sample_vld) begin
        n_cmp = n_cmp + 1;
        if (exp_q.size() == 0) begin
          n_bad = n_bad + 1;
          $display("FAIL unexpected_vld: got left=%h right=%h, required no strobe",
                   left_data, right_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (left_data !== mon_e.l || right_data !== mon_e.r) begin
            n_bad = n_bad + 1;
            $display("FAIL pair: got left=%h right=%h, required left=%h right=%h",
                     left_data, right_data, mon_e.l, mon_e.r);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Transmitter changes ws/sdata on the bclk falling edge.
  task automatic send_bit(input logic w, input logic d);
    bclk  = 1'b0;
    ws    = w;
    sdata = d;
    #(HALF_BCLK);
    bclk  = 1'b1;
    #(HALF_BCLK);
  endtask

  // Slot of nslot bits carrying an nword-bit value MSB first, padded with 1s.
  // ws flips one bit early, on the LSB, as in Philips I2S.
  task automatic send_slot(input logic [DW-1:0] val, input int nword,
                           input int nslot, input logic wsv);
    for (int k = 0; k < nslot; k++) begin
      send_bit((k == nslot - 1) ? ~wsv : wsv, (k < nword) ? val[nword-1-k] : 1'b1);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input int nword, input int nslot);
    send_slot(l, nword, nslot, 1'b0);
    send_slot(r, nword, nslot, 1'b1);
  endtask

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    exp_q.push_back(p);
  endtask

  task automatic phase_end(input string name, input int exp_err);
    #(200);
    check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({name, "_frame_err_count"}, 64'(err_seen - err_base), 64'(exp_err));
    err_base = err_seen;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [DW-1:0] rst_word;

  initial begin
    sys_rst = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;
    check("reset_left_data",  64'(left_data),  64'd0);
    check("reset_right_data", 64'(right_data), 64'd0);
    check("reset_sample_vld", 64'(sample_vld), 64'd0);
    check("reset_frame_err",  64'(frame_err),  64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b1;

    // Start in the middle of a right slot: nothing until a full pair follows.
    for (int k = 0; k < 8; k++) send_bit(1'b1, k[0]);
    send_bit(1'b0, 1'b1);
    repeat (3) begin
      push(24'h123456, 24'hABCDEF);
      send_frame(24'h123456, 24'hABCDEF, 24, 32);
    end
    phase_end("normal32", 0);

    // 16-bit slots: left-justified, both slots short.
    repeat (2) begin
      push(24'h800100, 24'h7FFF00);
      send_frame(24'h008001, 24'h007FFF, 16, 16);
    end
    phase_end("short16", 4);

    // Full-scale words and an exactly DATA_W-bit slot.
    push(24'h800000, 24'h7FFFFF);
    send_frame(24'h800000, 24'h7FFFFF, 24, 32);
    push(24'hA5A5A5, 24'h5A5A5A);
    send_frame(24'hA5A5A5, 24'h5A5A5A, 24, 24);
    push(24'h7FFFFF, 24'h800000);
    send_frame(24'h7FFFFF, 24'h800000, 24, 32);
    phase_end("fullscale", 0);

    // ws stuck low: one lost-sync error, outputs hold.
    repeat (80) send_bit(1'b0, 1'b1);
    phase_end("stuck", 1);
    check("hold_left_data",  64'(left_data),  64'h7FFFFF);
    check("hold_right_data", 64'(right_data), 64'h800000);
    // First frame re-aligns, second produces output.
    send_frame(24'h111111, 24'h222222, 24, 32);
    push(24'h654321, 24'hFEDCBA);
    send_frame(24'h654321, 24'hFEDCBA, 24, 32);
    phase_end("recover", 0);

    // Reset pulse in the middle of a left slot.
    rst_word = 24'hDEADBE;
    for (int k = 0; k < 32; k++) begin
      if (k == 10) begin
        #37;
        sys_rst = 1'b0;
        #1;
        check("midrst_left_data",  64'(left_data),  64'd0);
        check("midrst_right_data", 64'(right_data), 64'd0);
        check("midrst_sample_vld", 64'(sample_vld), 64'd0);
        check("midrst_frame_err",  64'(frame_err),  64'd0);
        #100;
        @(negedge sys_clk);
        sys_rst = 1'b1;
      end
      send_bit(k == 31, (k < 24) ? rst_word[23-k] : 1'b1);
    end
    send_slot(24'h00FFFF, 24, 32, 1'b1);
    push(24'h0F0F0F, 24'hF0F0F0);
    send_frame(24'h0F0F0F, 24'hF0F0F0, 24, 32);
    phase_end("after_reset", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_i2s_rx_deser
`default_nettype wire
